stopwatch_controller: RTL and testbench

//  Sequences the stopwatch time base and feeds minutes/seconds to seven_segment_driver.
//  - Turns single-cycle start/stop, lap and clear pulses into run/pause/lap/idle control.
//  - Prescales the board clock to a 1 s tick and keeps the seconds (0-59) and minutes counters.
//  - Drives minutes_out/seconds_out: live count, or a frozen lap snapshot.

---
 rtl/stopwatch_controller_pkg.sv | 18 +
 rtl/tick_generator.sv | 38 +++
 rtl/stopwatch_controller.sv | 137 +++++++++++++
 tb/tb_stopwatch_controller.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_controller_pkg.sv
// Shared definitions for the stopwatch slice: FSM encodings, count limits and defaults.
package stopwatch_controller_pkg;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StPause = 2'd2;
    localparam logic [1:0] StLap   = 2'd3;

    localparam int unsigned SecMax            = 59;
    localparam int unsigned DefaultTickDiv    = 50_000_000;
    localparam int unsigned DefaultMaxMinutes = 99;

    // The time base advances only while the stopwatch is live.
    function automatic logic is_counting(logic [1:0] st);
        return (st == StRun) || (st == StLap);
    endfunction

endpackage

// File: rtl/tick_generator.sv
// Prescaler that divides the board clock down to a single-cycle tick every TICK_DIV cycles.
module tick_generator
    import stopwatch_controller_pkg::*;
#(
    parameter int unsigned TICK_DIV = DefaultTickDiv
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = enable && !clear && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: run/pause/lap/idle control, mm:ss counters and registered display outputs.
module stopwatch_controller
    import stopwatch_controller_pkg::*;
#(
    parameter int unsigned TICK_DIV    = DefaultTickDiv,
    parameter int unsigned MAX_MINUTES = DefaultMaxMinutes
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_stop_pulse,
    input  logic       lap_pulse,
    input  logic       clear_pulse,
    output logic [6:0] minutes_out,
    output logic [6:0] seconds_out,
    output logic       running,
    output logic       lap_active,
    output logic       overflow
);

    localparam logic [6:0] MinLimit = 7'(MAX_MINUTES);
    localparam logic [6:0] SecLimit = 7'(SecMax);

    logic [1:0] state_q, state_d;
    logic [6:0] sec_q, sec_d, min_q, min_d;
    logic [6:0] snap_sec_q, snap_sec_d, snap_min_q, snap_min_d;
    logic [6:0] disp_sec_d, disp_min_d;
    logic       ovf_q, ovf_d;
    logic       tick, presc_clear, at_limit, hit_limit;

    tick_generator #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_generator (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (is_counting(state_q)),
        .clear   (presc_clear),
        .tick    (tick)
    );

    always_comb begin
        state_d     = state_q;
        sec_d       = sec_q;
        min_d       = min_q;
        snap_sec_d  = snap_sec_q;
        snap_min_d  = snap_min_q;
        ovf_d       = ovf_q;
        presc_clear = 1'b0;
        at_limit    = (min_q == MinLimit) && (sec_q == SecLimit);
        hit_limit   = tick && at_limit;

        // The tick lands first so any state change below sees the updated count.
        if (tick) begin
            if (at_limit) begin
                ovf_d = 1'b1;
            end else if (sec_q == SecLimit) begin
                sec_d = '0;
                min_d = min_q + 7'd1;
            end else begin
                sec_d = sec_q + 7'd1;
            end
        end

        case (state_q)
            StIdle: begin
                if (start_stop_pulse) begin
                    state_d     = StRun;
                    presc_clear = 1'b1;
                end
            end
            StRun: begin
                if (hit_limit || start_stop_pulse) begin
                    state_d = StPause;
                end else if (lap_pulse) begin
                    state_d    = StLap;
                    snap_sec_d = sec_d;
                    snap_min_d = min_d;
                end
            end
            StLap: begin
                if (hit_limit || start_stop_pulse) begin
                    state_d = StPause;
                end else if (lap_pulse) begin
                    state_d = StRun;
                end
            end
            StPause: begin
                if (clear_pulse) begin
                    state_d     = StIdle;
                    sec_d       = '0;
                    min_d       = '0;
                    snap_sec_d  = '0;
                    snap_min_d  = '0;
                    ovf_d       = 1'b0;
                    presc_clear = 1'b1;
                end else if (start_stop_pulse && !ovf_q) begin
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StLap) begin
            disp_min_d = snap_min_d;
            disp_sec_d = snap_sec_d;
        end else begin
            disp_min_d = min_d;
            disp_sec_d = sec_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            sec_q       <= '0;
            min_q       <= '0;
            snap_sec_q  <= '0;
            snap_min_q  <= '0;
            ovf_q       <= 1'b0;
            minutes_out <= '0;
            seconds_out <= '0;
        end else begin
            state_q     <= state_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            snap_sec_q  <= snap_sec_d;
            snap_min_q  <= snap_min_d;
            ovf_q       <= ovf_d;
            minutes_out <= disp_min_d;
            seconds_out <= disp_sec_d;
        end
    end

    assign running    = is_counting(state_q);
    assign lap_active = (state_q == StLap);
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller with TICK_DIV=4, MAX_MINUTES=2.
module tb_stopwatch_controller;

    localparam int Div    = 4;
    localparam int MaxMin = 2;
    localparam int Limit  = MaxMin * 60 + 59;
    localparam int MIdle  = 0;
    localparam int MRun   = 1;
    localparam int MPause = 2;
    localparam int MLap   = 3;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ss = 1'b0, lap = 1'b0, clr = 1'b0;
    logic [6:0] minutes_out, seconds_out;
    logic       running, lap_active, overflow;
    logic [16:0] dut_vec;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed live cycles, displayed time derived by division.
    int m_mode = MIdle;
    int m_elapsed = 0;
    int m_snap = 0;

    stopwatch_controller #(
        .TICK_DIV    (Div),
        .MAX_MINUTES (MaxMin)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start_stop_pulse (ss),
        .lap_pulse        (lap),
        .clear_pulse      (clr),
        .minutes_out      (minutes_out),
        .seconds_out      (seconds_out),
        .running          (running),
        .lap_active       (lap_active),
        .overflow         (overflow)
    );

    always #5 clock = ~clock;

    assign dut_vec = {minutes_out, seconds_out, running, lap_active, overflow};

    function automatic bit model_ovf();
        return m_elapsed >= Div * (Limit + 1);
    endfunction

    function automatic int live_secs();
        int t = m_elapsed / Div;
        return (t > Limit) ? Limit : t;
    endfunction

    function automatic logic [16:0] exp_vec();
        int s = (m_mode == MLap) ? m_snap : live_secs();
        return {7'(s / 60), 7'(s % 60), (m_mode == MRun) || (m_mode == MLap),
                m_mode == MLap, model_ovf()};
    endfunction

    task automatic model_reset();
        m_mode = MIdle;
        m_elapsed = 0;
        m_snap = 0;
    endtask

    task automatic model_step(input bit s, input bit l, input bit c);
        bit live = (m_mode == MRun) || (m_mode == MLap);
        bit hit;
        if (live) m_elapsed++;
        hit = live && (m_elapsed == Div * (Limit + 1));
        case (m_mode)
            MIdle: if (s) m_mode = MRun;
            MRun: begin
                if (hit || s) m_mode = MPause;
                else if (l) begin
                    m_mode = MLap;
                    m_snap = live_secs();
                end
            end
            MLap: begin
                if (hit || s) m_mode = MPause;
                else if (l) m_mode = MRun;
            end
            default: begin
                if (c) begin
                    m_mode = MIdle;
                    m_elapsed = 0;
                    m_snap = 0;
                end else if (s && !model_ovf()) begin
                    m_mode = MRun;
                end
            end
        endcase
    endtask

    task automatic step(input bit s, input bit l, input bit c);
        @(negedge clock);
        ss = s;
        lap = l;
        clr = c;
        @(posedge clock);
        model_step(s, l, c);
        #1;
        ss = 1'b0;
        lap = 1'b0;
        clr = 1'b0;
    endtask

    task automatic go_idle();
        if (m_mode == MRun || m_mode == MLap) step(1, 0, 0);
        if (m_mode == MPause) step(0, 0, 1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (dut_vec !== 17'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", dut_vec, 17'd0);
        end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_count();
        step(1, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            step(0, 0, 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL count_model k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
            checks++;
            if (seconds_out !== 7'(k / 4) || running !== 1'b1) begin
                errors++;
                $display("FAIL count_seconds k=%0d: got %0d/%b want %0d/1", k, seconds_out,
                         running, k / 4);
            end
        end
    endtask

    task automatic test_minute_rollover();
        int guard = 0;
        while (live_secs() < 59 && guard < 400) begin
            step(0, 0, 0);
            guard++;
        end
        checks++;
        if (minutes_out !== 7'd0 || seconds_out !== 7'd59) begin
            errors++;
            $display("FAIL at_0059: got %0d:%0d want 0:59", minutes_out, seconds_out);
        end
        guard = 0;
        while (live_secs() < 60 && guard < 8) begin
            step(0, 0, 0);
            guard++;
        end
        checks++;
        if (minutes_out !== 7'd1 || seconds_out !== 7'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rollover_0100: got %0d:%0d ovf=%b want 1:0 ovf=0", minutes_out,
                     seconds_out, overflow);
        end
    endtask

    task automatic test_lap();
        int guard = 0;
        go_idle();
        step(1, 0, 0);
        while (live_secs() < 5 && guard < 40) begin
            step(0, 0, 0);
            guard++;
        end
        step(0, 1, 0);
        for (int k = 0; k < 12; k++) begin
            step(0, 0, 0);
            checks++;
            if (seconds_out !== 7'd5 || minutes_out !== 7'd0 || lap_active !== 1'b1
                || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL lap_hold k=%0d: got %h want 00:05 lap (model %h)", k, dut_vec,
                         exp_vec());
            end
        end
        step(0, 1, 0);
        checks++;
        if (seconds_out !== 7'd8 || lap_active !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL lap_release: got %h sec=%0d want sec=8 (model %h)", dut_vec,
                     seconds_out, exp_vec());
        end
    endtask

    task automatic test_pause();
        logic [16:0] held;
        int guard = 0;
        while (m_elapsed % Div != 1 && guard < 8) begin
            step(0, 0, 0);
            guard++;
        end
        step(1, 0, 0);
        held = dut_vec;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0);
            checks++;
            if (dut_vec !== held || running !== 1'b0 || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL pause_hold k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
        step(1, 0, 0);
        guard = 0;
        while (seconds_out === held[9:3] && guard < 10) begin
            step(0, 0, 0);
            guard++;
        end
        checks++;
        if (guard !== 2 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL resume_tick: got %0d cycles %h want 2 cycles %h", guard, dut_vec,
                     exp_vec());
        end
        step(1, 0, 0);
        step(0, 0, 1);
        checks++;
        if (dut_vec !== 17'd0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL pause_clear: got %h want %h", dut_vec, 17'd0);
        end
    endtask

    task automatic test_overflow();
        int guard = 0;
        go_idle();
        step(1, 0, 0);
        while (!model_ovf() && guard < 800) begin
            step(0, 0, 0);
            guard++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL overflow_run g=%0d: got %h want %h", guard, dut_vec, exp_vec());
            end
        end
        checks++;
        if (minutes_out !== 7'd2 || seconds_out !== 7'd59 || overflow !== 1'b1
            || running !== 1'b0) begin
            errors++;
            $display("FAIL overflow_sat: got %0d:%0d ovf=%b run=%b want 2:59 ovf=1 run=0",
                     minutes_out, seconds_out, overflow, running);
        end
        step(1, 0, 0);
        repeat (6) step(0, 0, 0);
        checks++;
        if (running !== 1'b0 || seconds_out !== 7'd59 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL overflow_start_ignored: got %h want %h", dut_vec, exp_vec());
        end
        step(0, 0, 1);
        checks++;
        if (dut_vec !== 17'd0) begin
            errors++;
            $display("FAIL overflow_clear: got %h want %h", dut_vec, 17'd0);
        end
    endtask

    task automatic test_priority();
        go_idle();
        step(1, 0, 0);
        repeat (7) step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        checks++;
        if (dut_vec !== 17'd0 || m_mode !== MIdle) begin
            errors++;
            $display("FAIL clear_beats_start: got %h want %h", dut_vec, 17'd0);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 2500; k++) begin
            step($urandom_range(15) == 0, $urandom_range(11) == 0, $urandom_range(5) == 0);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random k=%0d: got %h want %h", k, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        go_idle();
        step(1, 0, 0);
        repeat (9) step(0, 0, 0);
        step(0, 1, 0);
        repeat (3) step(0, 0, 0);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 17'd0) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", dut_vec, 17'd0);
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        step(1, 0, 0);
        step(0, 0, 0);
        checks++;
        if (dut_vec !== exp_vec() || lap_active !== 1'b0 || seconds_out !== 7'd0) begin
            errors++;
            $display("FAIL no_stale_lap: got %h want %h", dut_vec, exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_minute_rollover();
        test_lap();
        test_pause();
        test_overflow();
        test_priority();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
